// File: rtl/asym_fifo_read_wider_if.sv
// Handshake bundle for the narrow-in / wide-out FIFO.
// A word moves on a rising edge where valid && ready; valid holds with stable data until then.
interface asym_fifo_read_wider_if #(
    parameter int WIDTHW     = 4,
    parameter int WIDTHR     = 16,
    parameter int ADDRWIDTHW = 10
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTHW-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTHR-1:0]     out_data;
    logic [ADDRWIDTHW:0]   level;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/asym_fifo_read_wider.sv
// Narrow-in / wide-out FIFO: packs RATIO narrow words (first word in the LSB lane)
// into one wide word, presented from a registered valid/ready output stage.
module asym_fifo_read_wider #(
    parameter int WIDTHW     = 4,
    parameter int WIDTHR     = 16,
    parameter int SIZEW      = 1024,
    parameter int ADDRWIDTHW = 10
) (
    input logic                    clk,
    input logic                    rst_n,
    asym_fifo_read_wider_if.slave  bus
);
    localparam int RATIO  = WIDTHR / WIDTHW;
    localparam int LOG2R  = $clog2(RATIO);
    localparam int RPW    = ADDRWIDTHW - LOG2R;
    localparam int DEPTHR = SIZEW / RATIO;

    localparam logic [ADDRWIDTHW:0]   LVL_FULL  = (ADDRWIDTHW+1)'(SIZEW);
    localparam logic [ADDRWIDTHW:0]   LVL_RATIO = (ADDRWIDTHW+1)'(RATIO);
    localparam logic [ADDRWIDTHW-1:0] LANE_MASK = ADDRWIDTHW'(RATIO - 1);

    logic [WIDTHR-1:0]     mem [DEPTHR];

    logic [ADDRWIDTHW-1:0] wp_q, wp_d;
    logic [RPW-1:0]        rp_q, rp_d;
    logic [ADDRWIDTHW:0]   level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTHR-1:0]     out_data_q;

    logic                  in_ready;
    logic                  accept;
    logic                  fetch;
    logic [RPW-1:0]        wr_row;
    logic [RATIO-1:0]      lane_we;

    // in_ready looks only at registered level, so out_ready never reaches it combinationally.
    assign in_ready = rst_n && (level_q < LVL_FULL) && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign fetch    = !bus.flush && (level_q >= LVL_RATIO) && (!out_valid_q || bus.out_ready);
    assign wr_row   = wp_q[ADDRWIDTHW-1:LOG2R];

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane_we[k] = accept && ((wp_q & LANE_MASK) == ADDRWIDTHW'(k));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < RATIO; k++) begin
            if (lane_we[k]) begin
                mem[wr_row][k*WIDTHW +: WIDTHW] <= bus.in_data;
            end
        end
    end

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            wp_d        = '0;
            rp_d        = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                wp_d = wp_q + 1'b1;
            end
            if (fetch) begin
                rp_d        = rp_q + 1'b1;
                out_valid_d = 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            level_d = level_q + (ADDRWIDTHW+1)'(accept) - (fetch ? LVL_RATIO : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Synchronous RAM read lands directly in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (fetch) begin
            out_data_q <= mem[rp_q];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.level     = level_q;
endmodule
